// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Glyphs are gfedcba, active-low.
package disp_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [1:0] SRC_LOSER  = 2'd0;
  localparam logic [1:0] SRC_WINNER = 2'd1;
  localparam logic [1:0] SRC_SCORE  = 2'd2;

  localparam logic [6:0] GLYPH_R     = 7'b0001000;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_V     = 7'b1000001;
  localparam logic [6:0] GLYPH_O     = 7'b1000000;
  localparam logic [6:0] GLYPH_M     = 7'b1001000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_G     = 7'b0000010;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Bit 0 has the highest priority.
  function automatic logic [1:0] top_req(input logic [2:0] r);
    if (r[0]) return SRC_LOSER;
    if (r[1]) return SRC_WINNER;
    return SRC_SCORE;
  endfunction

  function automatic logic [2:0] src_onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Digit-scan timebase: a slot of SCAN_DIV clocks per digit, eight slots per frame.
module disp_scan_timer #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] digit,
  output logic       tick,
  output logic       frame_end
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] sc;

  assign tick      = (sc == SW'(SCAN_DIV - 1));
  assign frame_end = tick && (digit == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc    <= '0;
      digit <= '0;
    end else if (tick) begin
      sc    <= '0;
      digit <= digit + 3'd1;
    end else begin
      sc <= sc + SW'(1);
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Fixed-priority arbiter for the shared 8-digit display: minimum hold time,
// one blank frame between messages, optional per-source blink.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned HOLD_FRAMES  = 125,
  parameter int unsigned BLINK_FRAMES = 62
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [55:0] seg_data0,
  input  logic [55:0] seg_data1,
  input  logic [55:0] seg_data2,
  input  logic [2:0]  blink,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic [2:0]  grant,
  output logic        busy
);

  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  logic [2:0]    digit;
  logic          unused_tick;
  logic          frame_end;

  state_t        state, state_n;
  logic [1:0]    cur, cur_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_phase, phase_n;
  logic          higher;

  logic [55:0]   src_data;
  logic [7:0]    an_n;
  logic [6:0]    seg_n;
  logic [2:0]    grant_n;

  disp_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .digit     (digit),
    .tick      (unused_tick),
    .frame_end (frame_end)
  );

  always_comb begin
    state_n     = state;
    cur_n       = cur;
    hold_n      = hold_cnt;
    blink_cnt_n = blink_cnt;
    phase_n     = blink_phase;
    higher      = |(req & ((3'b001 << cur) - 3'b001));
    if (frame_end) begin
      case (state)
        IDLE, BLANK: begin
          if (|req) begin
            state_n     = SHOW;
            cur_n       = top_req(req);
            hold_n      = '0;
            blink_cnt_n = '0;
            phase_n     = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
        SHOW: begin
          if (hold_cnt < HW'(HOLD_FRAMES)) hold_n = hold_cnt + HW'(1);
          if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_n = '0;
            phase_n     = ~blink_phase;
          end else begin
            blink_cnt_n = blink_cnt + BW'(1);
          end
          // Preemption tests the count from before this frame's increment.
          if (!req[cur]) state_n = BLANK;
          else if (higher && hold_cnt >= HW'(HOLD_FRAMES - 1)) state_n = BLANK;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    case (cur)
      2'd0:    src_data = seg_data0;
      2'd1:    src_data = seg_data1;
      default: src_data = seg_data2;
    endcase
    an_n    = 8'hFF;
    seg_n   = GLYPH_BLANK;
    grant_n = '0;
    if (state == SHOW) begin
      seg_n   = src_data[7*digit +: 7];
      grant_n = src_onehot(cur);
      if (!(blink[cur] && blink_phase)) an_n = ~(8'b1 << digit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= '0;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      hold_cnt    <= hold_n;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= phase_n;
    end
  end

  // busy is registered with the other outputs so all four move on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an    <= 8'hFF;
      seg   <= GLYPH_BLANK;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      an    <= an_n;
      seg   <= seg_n;
      grant <= grant_n;
      busy  <= (state != IDLE);
    end
  end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
Scheduler and arbiter for the shared 8-digit seven-segment display on the Nexys4 board. Up to three message sources request the display: 0 = loser banner, 1 = winner banner, 2 = score/timer. The block owns the digit-scan timing, grants the display to one source under fixed priority with a minimum hold time, and inserts a blank frame between messages. It drives the board anodes and segments directly and replaces per-message scan logic inside each display module.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate, 125 Hz frame at 100 MHz)
HOLD_FRAMES, 125, minimum frames a granted message is shown before a higher-priority source may preempt it (1 s)
BLINK_FRAMES, 62, frames per blink half-period

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  3  display request per source; bit 0 has the highest priority
seg_data0  in  56  source 0 glyphs; digit i = bits [7i+6:7i], gfedcba, active-low
seg_data1  in  56  source 1 glyphs, same format
seg_data2  in  56  source 2 glyphs, same format
blink  in  3  per-source blink enable
an  out  8  digit anodes, active-low, at most one low
seg  out  7  segments gfedcba, active-low
grant  out  3  one-hot, identifies the source currently shown; 000 when none
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (reset=0, async): an=8'hFF, seg=7'h7F, grant=000, busy=0, state=IDLE. All counters and blink_phase clear to 0.
- Scan timer:
  - sc counts 0..SCAN_DIV-1. tick is asserted when sc==SCAN_DIV-1; sc then wraps to 0.
  - digit (3 bit) increments on tick and wraps 7->0.
  - frame_end = tick && digit==7.
- State changes, arbitration and hold_cnt updates occur only on frame_end.
- States:
  - IDLE: an=FF. On frame_end with any req set, cur <= highest-priority requester, hold_cnt <= 0, blink_phase <= 0, go to SHOW.
  - SHOW, at frame_end:
    - hold_cnt increments, saturating at HOLD_FRAMES.
    - If req[cur]==0: go to BLANK.
    - Else if a source with higher priority than cur requests and hold_cnt >= HOLD_FRAMES-1: go to BLANK.
    - Otherwise stay in SHOW. A lower-priority source never preempts.
  - BLANK: exactly one full frame with an=FF and grant=000. At the next frame_end, re-arbitrate as in IDLE; with no requests, go to IDLE.
- Output path:
  - In SHOW, an = ~(1<<digit) and seg = seg_dataN[digit slice] with N=cur. Both are registered, one cycle after digit changes.
  - Source data is sampled live, not latched, so score updates appear on the next slot.
  - In IDLE/BLANK, seg=7F.
- Blink: in SHOW with blink[cur]=1, blink_phase toggles every BLINK_FRAMES frames, and an=FF while blink_phase=1. When blink[cur]=0, blink_phase is ignored.
- grant is registered and equals onehot(cur) only in SHOW.
- Simultaneous requests are resolved by priority. A requester dropping and reasserting within one frame is not seen; only frame_end sampling counts.
- Reset asserted mid-frame returns to IDLE immediately. After release, the first grant happens at the first frame_end.

Decomposition:
- Package disp_pkg holds:
  - state enum {IDLE, SHOW, BLANK};
  - source indices SRC_LOSER=0, SRC_WINNER=1, SRC_SCORE=2;
  - glyph constants (R=0001000, E=0000110, V=1000001, O=1000000, M=1001000, A=0001000, G=0000010, BLANK=1111111).
- One sub-module, disp_scan_timer (params SCAN_DIV; outputs digit, tick, frame_end), is natural and reusable. Arbitration and FSM stay in disp_arbiter.

Test Plan (SCAN_DIV=4, HOLD_FRAMES=2, BLINK_FRAMES=1; frame = 32 cycles):
1. Reset low with req=111 -> an=FF, seg=7F, grant=000, busy=0 for the whole reset period.
2. Release reset, req=100, seg_data2 digit i = glyph i -> grant=100 after the first frame_end; an steps FE,FD,FB,..,7F, 4 cycles each; seg matches each slice one cycle after the digit changes.
3. While showing source 2 with hold_cnt=0, raise req[0] -> source 2 stays displayed until hold_cnt reaches 1 at a frame_end; then one frame with an=FF and grant=000; then grant=001 showing seg_data0 ("REVO EMAG" pattern).
4. In SHOW cur=0, drop req[0] with req[2] still set -> exactly one blank frame, then grant=100. Drop all requests -> blank frame, then IDLE with busy=0.
5. blink=001 with source 0 shown -> an alternates between one full scanning frame and one frame of an=FF; seg unaffected.
6. Assert reset mid-SHOW at digit 3 -> an=FF and grant=000 in the same cycle (async); after release, the first grant comes only at the next frame_end.
